// File: rtl/filtro_iir_secuencial_pkg.sv
// Shared definitions for the IIR filter sections and the band-selected
// coefficient multiplexers: number format, band codes, FSM encoding and
// saturation limits.
package filtro_iir_secuencial_pkg;

  localparam int WIDTH     = 22;
  localparam int FRAC      = 14;
  localparam int ACC_WIDTH = 2 * WIDTH + 4;

  // Band codes driven on coef_band
  localparam logic [1:0] BAND_BYPASS = 2'b00;
  localparam logic [1:0] BAND_BAJO   = 2'b01;
  localparam logic [1:0] BAND_MEDIO  = 2'b10;
  localparam logic [1:0] BAND_ALTO   = 2'b11;

  // Saturation limits of a WIDTH-bit signed sample
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Index of the last MAC term (a2*y2)
  localparam logic [2:0] K_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MAC  = 2'b01,
    S_OUT  = 2'b10
  } state_t;

endpackage

// File: rtl/filtro_iir_secuencial_saturador_q.sv
// Accumulator to sample conversion: arithmetic shift right by FRAC
// (rounds toward minus infinity) followed by saturation to WIDTH bits.
module saturador_q
  import filtro_iir_secuencial_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0]     y
);

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic        [ACC_WIDTH-WIDTH:0] upper;
  logic                         fits;

  // The value fits when every bit above the sample sign bit copies it
  always_comb begin
    shifted = acc >>> FRAC;
    upper   = shifted[ACC_WIDTH-1:WIDTH-1];
    fits    = (&upper) | ~(|upper);
    if (fits) begin
      y = shifted[WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      y = SAT_MIN;
    end else begin
      y = SAT_MAX;
    end
  end

endmodule

// File: rtl/filtro_iir_secuencial.sv
// Second-order IIR section computed sequentially with one shared multiplier:
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] - a2*y[n-2]
// Handshake: x_valid is a one-cycle strobe, accepted only in IDLE; a strobe
// while busy is dropped and answered by a one-cycle overrun pulse. y_valid is
// a one-cycle strobe marking a new y_out. There is no backpressure on output.
module filtro_iir_secuencial
  import filtro_iir_secuencial_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  input  logic [1:0]       band_in,
  output logic [1:0]       coef_band,
  input  logic [WIDTH-1:0] coef_a1,
  input  logic [WIDTH-1:0] coef_a2,
  input  logic [WIDTH-1:0] coef_b0,
  input  logic [WIDTH-1:0] coef_b1,
  input  logic [WIDTH-1:0] coef_b2,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       state_dbg
);

  state_t state, state_next;

  logic signed [WIDTH-1:0]     x0, x1, x2, y1, y2;
  logic signed [ACC_WIDTH-1:0] acc;
  logic        [2:0]           k;

  logic signed [WIDTH-1:0]     op_coef, op_data;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] term;
  logic signed [WIDTH-1:0]     sat_y;
  logic signed [WIDTH-1:0]     y_next;
  logic                        bypass;
  logic                        mac_en;
  logic                        out_en;
  logic                        accept;

  saturador_q u_sat (
    .acc (acc),
    .y   (sat_y)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: five MAC cycles then one output cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (x_valid) state_next = S_MAC;
      S_MAC:   if (k == K_LAST) state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state != S_IDLE);
    accept    = (state == S_IDLE) && x_valid;
    mac_en    = (state == S_MAC);
    out_en    = (state == S_OUT);
    state_dbg = state;
  end

  // Operand selection for the shared multiplier; a2 term is subtracted
  always_comb begin
    op_coef = '0;
    op_data = '0;
    case (k)
      3'd0: begin op_coef = coef_b0; op_data = x0; end
      3'd1: begin op_coef = coef_b1; op_data = x1; end
      3'd2: begin op_coef = coef_b2; op_data = x2; end
      3'd3: begin op_coef = coef_a1; op_data = y1; end
      3'd4: begin op_coef = coef_a2; op_data = y2; end
      default: begin op_coef = '0; op_data = '0; end
    endcase
    prod = op_coef * op_data;
    term = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    if (k == K_LAST) begin
      term = -term;
    end
  end

  // Bypass passes the latched sample through untouched
  always_comb begin
    bypass = (coef_band == BAND_BYPASS);
    y_next = bypass ? x0 : sat_y;
  end

  // Datapath: sample latch, accumulation, output and history update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      k         <= '0;
      coef_band <= BAND_BYPASS;
      y_out     <= '0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      overrun <= x_valid && busy;
      if (accept) begin
        x0        <= x_in;
        coef_band <= band_in;
        acc       <= '0;
        k         <= '0;
        // Switching band restarts the recursion from rest
        if (band_in != coef_band) begin
          x1 <= '0;
          x2 <= '0;
          y1 <= '0;
          y2 <= '0;
        end
      end
      if (mac_en) begin
        acc <= acc + term;
        k   <= k + 3'd1;
      end
      if (out_en) begin
        y_out   <= y_next;
        y_valid <= 1'b1;
        if (bypass) begin
          x1 <= '0;
          x2 <= '0;
          y1 <= '0;
          y2 <= '0;
        end else begin
          x2 <= x1;
          x1 <= x0;
          y2 <= y1;
          y1 <= sat_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_filtro_iir_secuencial.sv
// Bench for filtro_iir_secuencial: band-indexed coefficient tables stand in
// for the coefficient muxes; a reference model produces expected samples.
module tb_filtro_iir_secuencial;

  logic        clk;
  logic        reset_n;
  logic [21:0] x_in;
  logic        x_valid;
  logic [1:0]  band_in;
  logic [1:0]  coef_band;
  logic [21:0] coef_a1, coef_a2, coef_b0, coef_b1, coef_b2;
  logic [21:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;
  logic [1:0]  state_dbg;

  logic signed [21:0] tab_a1[4];
  logic signed [21:0] tab_a2[4];
  logic signed [21:0] tab_b0[4];
  logic signed [21:0] tab_b1[4];
  logic signed [21:0] tab_b2[4];

  assign coef_a1 = tab_a1[coef_band];
  assign coef_a2 = tab_a2[coef_band];
  assign coef_b0 = tab_b0[coef_band];
  assign coef_b1 = tab_b1[coef_band];
  assign coef_b2 = tab_b2[coef_band];

  filtro_iir_secuencial dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .band_in   (band_in),
    .coef_band (coef_band),
    .coef_a1   (coef_a1),
    .coef_a2   (coef_a2),
    .coef_b0   (coef_b0),
    .coef_b1   (coef_b1),
    .coef_b2   (coef_b2),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;
  int yv_count = 0;
  int ov_count = 0;

  // Scoreboard
  logic [21:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [21:0] mon_e;
  int          mon_c;

  // Reference model state
  longint m_x1, m_x2, m_y1, m_y2;
  logic [1:0] m_band;

  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      yv_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_y_valid: y_out=%h with no sample pending (cycle %0d)", y_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (y_out !== mon_e) begin
          miscompares++;
          $display("FAIL y_out: got %h expected %h (cycle %0d)", y_out, mon_e, cyc);
        end
        vectors++;
        if (cyc !== mon_c) begin
          miscompares++;
          $display("FAIL latency: y_valid at cycle %0d expected cycle %0d", cyc, mon_c);
        end
      end
    end
    if (overrun === 1'b1) ov_count++;
  end

  task automatic model_reset();
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    m_band = 2'b00;
  endtask

  task automatic set_coefs(input logic [1:0] band, input int b0, input int b1,
                           input int b2, input int a1, input int a2);
    tab_b0[band] = b0[21:0];
    tab_b1[band] = b1[21:0];
    tab_b2[band] = b2[21:0];
    tab_a1[band] = a1[21:0];
    tab_a2[band] = a2[21:0];
  endtask

  // Driver: called on a falling edge; strobe is sampled at the next rising edge
  task automatic send(input logic [1:0] band, input logic [21:0] x);
    longint xs, acc, r;
    logic [21:0] y;
    xs = longint'($signed(x));
    if (band != m_band) begin
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    end
    if (band == 2'b00) begin
      y = x;
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    end else begin
      acc = longint'(tab_b0[band]) * xs + longint'(tab_b1[band]) * m_x1
          + longint'(tab_b2[band]) * m_x2 + longint'(tab_a1[band]) * m_y1
          - longint'(tab_a2[band]) * m_y2;
      r = acc >>> 14;
      if (r > 64'sd2097151) r = 64'sd2097151;
      if (r < -64'sd2097152) r = -64'sd2097152;
      y = r[21:0];
      m_x2 = m_x1; m_x1 = xs;
      m_y2 = m_y1; m_y1 = r;
    end
    m_band = band;
    exp_q.push_back(y);
    exp_cyc_q.push_back(cyc + 7);
    x_in = x; band_in = band; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  // Strobe that the DUT is expected to drop
  task automatic strobe_raw(input logic [1:0] band, input logic [21:0] x);
    x_in = x; band_in = band; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d samples still pending, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (y_out !== 22'h0) begin miscompares++; $display("FAIL reset_y_out: got %h expected 0", y_out); end
    vectors++;
    if (y_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: y_valid=%b busy=%b overrun=%b expected 0 0 0", y_valid, busy, overrun);
    end
    vectors++;
    if (coef_band !== 2'b00 || state_dbg !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_band_state: coef_band=%b state=%b expected 00 00", coef_band, state_dbg);
    end
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_bypass();
    send(2'b00, 22'h004000);
    vectors++;
    if (busy !== 1'b1 || coef_band !== 2'b00) begin
      miscompares++;
      $display("FAIL bypass_busy: busy=%b coef_band=%b expected 1 00", busy, coef_band);
    end
    wait_drain();
    vectors++;
    if (dut.x1 !== 22'h0 || dut.x2 !== 22'h0 || dut.y1 !== 22'h0 || dut.y2 !== 22'h0) begin
      miscompares++;
      $display("FAIL bypass_history: x1=%h x2=%h y1=%h y2=%h expected all 0", dut.x1, dut.x2, dut.y1, dut.y2);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL bypass_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_impulse();
    set_coefs(2'b01, 16384, 0, 0, 8192, 0);
    send(2'b01, 22'd16384);
    for (int i = 0; i < 3; i++) begin
      repeat (6) @(negedge clk);
      send(2'b01, 22'd0);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    set_coefs(2'b01, 32702, 0, 0, 0, 0);
    send(2'b01, 22'h1FFFFF);
    repeat (6) @(negedge clk);
    send(2'b01, 22'h200000);
    wait_drain();
  endtask

  task automatic test_overrun();
    int ov0, yv0;
    set_coefs(2'b01, 16384, 0, 0, 0, 0);
    ov0 = ov_count; yv0 = yv_count;
    send(2'b01, 22'd1000);
    repeat (2) @(negedge clk);
    strobe_raw(2'b11, 22'd5555);
    wait_drain();
    vectors++;
    if (ov_count - ov0 !== 1) begin miscompares++; $display("FAIL overrun_count: got %0d pulses expected 1", ov_count - ov0); end
    vectors++;
    if (yv_count - yv0 !== 1) begin miscompares++; $display("FAIL overrun_y_valid: got %0d strobes expected 1", yv_count - yv0); end
    vectors++;
    if (coef_band !== 2'b01) begin miscompares++; $display("FAIL overrun_band: coef_band=%b expected 01", coef_band); end
    // Strobe landing on the output cycle is dropped as well
    ov0 = ov_count;
    send(2'b01, 22'd2000);
    repeat (5) @(negedge clk);
    strobe_raw(2'b10, 22'd7777);
    wait_drain();
    vectors++;
    if (ov_count - ov0 !== 1) begin miscompares++; $display("FAIL overrun_out_cycle: got %0d pulses expected 1", ov_count - ov0); end
  endtask

  task automatic test_band_change();
    set_coefs(2'b01, 16384, 8192, 4096, 8192, 2048);
    set_coefs(2'b10, 16384, 16384, 16384, 16384, 16384);
    for (int i = 0; i < 3; i++) begin
      send(2'b01, 22'd8000);
      repeat (6) @(negedge clk);
    end
    send(2'b10, 22'd4096);
    wait_drain();
    vectors++;
    if (y_out !== 22'd4096) begin miscompares++; $display("FAIL band_change_y: got %h expected %h", y_out, 22'd4096); end
  endtask

  task automatic test_reset_mid_mac();
    int yv0;
    set_coefs(2'b01, 16384, 16384, 0, 8192, 0);
    send(2'b01, 22'd3000);
    repeat (6) @(negedge clk);
    send(2'b01, 22'd3000);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (y_out !== 22'h0 || y_valid !== 1'b0 || busy !== 1'b0 || coef_band !== 2'b00 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mac: y_out=%h y_valid=%b busy=%b band=%b overrun=%b expected 0", y_out, y_valid, busy, coef_band, overrun);
    end
    // The interrupted sample is lost (the first one already completed)
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    model_reset();
    yv0 = yv_count;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (yv_count - yv0 !== 0) begin miscompares++; $display("FAIL reset_no_y_valid: got %0d strobes expected 0", yv_count - yv0); end
    send(2'b01, 22'd3000);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int b = 1; b < 4; b++) begin
      set_coefs(b[1:0], $urandom_range(0, 16384) - 8192, $urandom_range(0, 16384) - 8192,
                $urandom_range(0, 16384) - 8192, $urandom_range(0, 16384) - 8192,
                $urandom_range(0, 16384) - 8192);
    end
    for (int i = 0; i < 24; i++) begin
      logic [1:0] band;
      logic [21:0] x;
      band = (i % 6 == 5) ? 2'($urandom_range(0, 3)) : 2'b01 + 2'(i / 8);
      x = 22'($urandom_range(0, 32'h3FFFFF));
      send(band, x);
      repeat (6 + $urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
  endtask

  initial begin
    reset_n = 1'b0;
    x_in = '0;
    x_valid = 1'b0;
    band_in = 2'b00;
    for (int b = 0; b < 4; b++) set_coefs(b[1:0], 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_impulse();
    test_saturation();
    test_overrun();
    test_band_change();
    test_reset_mid_mac();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filtro_iir_secuencial.md
Name: filtro_iir_secuencial

Overview:
Sequential second-order recursive (IIR) filter section. It is the consumer of the band-selected coefficient multiplexers for a1, a2, b0, b1 and b2.
- Drives the shared band select to those muxes.
- Reads the five returned Q-format coefficients.
- Computes one output sample per input strobe using a single time-shared multiplier.
- Sits between the sample source (ADC/decimator) and the output stage.

Parameters:
Width, 22, sample and coefficient width, signed two's complement.
Frac, 14, fractional bits of samples and coefficients (Q8.14; 1.0 = 16384).
AccWidth, 48, accumulator width (2*Width+4).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
x_in  in  Width  input sample, signed Q8.14.
x_valid  in  1  one-cycle strobe: x_in and band_in are valid.
band_in  in  2  requested band (00 bypass, 01 bajo, 10 medio, 11 alto).
coef_band  out  2  band select to all coefficient muxes; held stable during computation.
coef_a1, coef_a2, coef_b0, coef_b1, coef_b2  in  Width each  coefficients returned by the muxes (combinational from coef_band).
y_out  out  Width  filtered sample, signed Q8.14.
y_valid  out  1  one-cycle strobe: y_out updated.
busy  out  1  computation in progress.
overrun  out  1  one-cycle pulse: x_valid arrived while busy.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n).
- Reset values: y_out=0, y_valid=0, busy=0, overrun=0, coef_band=00. History x1, x2, y1, y2 = 0. Accumulator = 0. State = IDLE.
- Equation: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] - a2*y[n-2].
- FSM states: IDLE, MAC, OUT.
- Edge E0, IDLE with x_valid=1:
  - Latch x_in into x0 and band_in into coef_band.
  - Clear acc and set term index k=0.
  - busy=1; go to MAC.
- Band change: if band_in differs from the coef_band latched for the previous sample, clear x1, x2, y1, y2 at E0. This avoids transients when switching bands.
- MAC, edges E1..E5: one product per edge, in order k=0..4: b0*x0, b1*x1, b2*x2, a1*y1, a2*y2.
  - Each product is the full 2*Width signed result, sign-extended to AccWidth.
  - The a2 term is subtracted; all others are added.
  - After k=4, go to OUT.
- OUT, edge E6:
  - r = acc >>> Frac (arithmetic shift; truncation toward minus infinity).
  - Saturate r to the Width signed range: max 0x1FFFFF, min 0x200000.
  - y_out=r; y_valid=1 for exactly one cycle.
  - Shift history: x2=x1, x1=x0, y2=y1, y1=r.
  - busy=0; go to IDLE.
- Latency: x_valid sampled at E0 gives y_valid high in the cycle following E6 (6 clocks). Maximum throughput is one sample per 7 clocks.
- Bypass (latched band 00): the MAC sequence still runs, keeping latency identical, but y_out = x0 unmodified.
  - History is cleared to 0 rather than updated.
  - The coefficient inputs are ignored.
- x_valid while busy (including the OUT cycle):
  - The sample is dropped and overrun pulses for one cycle.
  - State, history and coef_band are unchanged.
- x_valid at E0 together with an unrelated band change is handled by the band-change rule above.
- coef_band must not change between E0 and E6. The coefficient inputs are sampled only in MAC.
- reset_n asserted mid-operation: immediate return to reset values. No y_valid is produced for the interrupted sample.

Decomposition:
- Shared package, also used by the coefficient mux blocks: Frac, band codes (BAND_BYPASS=00, BAND_BAJO=01, BAND_MEDIO=10, BAND_ALTO=11), FSM state encoding, and the saturation limits derived from Width.
- One natural sub-module, saturador_q: combinational AccWidth-to-Width shift-and-saturate. It is reusable by the other filter sections.

Test Plan:
- Bypass: band 00, x=0x004000 (1.0) -> y_out=0x004000, y_valid exactly 6 clocks after the strobe, history remains 0.
- Impulse response: band 01, b0=16384, a1=8192, other coefficients 0; send x=16384, then three zeros, 7 clocks apart -> y = 16384, 8192, 4096, 2048.
- Saturation:
  - b0=32702 (1.996), x=0x1FFFFF -> y=0x1FFFFF.
  - x=0x200000 -> y=0x200000.
- Overrun: second x_valid 3 clocks after the first -> overrun pulses once, only one y_valid, and y matches the single-sample expectation.
- Band change: build nonzero history in band 01, then send a sample with band 10 -> history cleared, so y equals b0*x only (b0=16384, x=4096 -> y=4096).
- Reset mid-MAC: drop reset_n at E3 -> all outputs 0 immediately, no y_valid; the next sample computes from zero history.
